// File: rtl/param_transmitter.sv
// Parameterised UART-style serial transmitter: start bit, DATA_BITS data bits
// (LSB first), optional odd/even parity, then STOP_BITS stop bits.
`timescale 1ns/1ps

module param_transmitter #(
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_MODE  = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 CLK,
    input  logic                 RST_N_in,
    input  logic                 Tx_DV_in,
    input  logic [DATA_BITS-1:0] Tx_Byte_in,
    output logic                 Tx_Ready_out,
    output logic                 Tx_Active_out,
    output logic                 Tx_Serial_out,
    output logic                 Tx_Done_out
);

    // Guards keep widths legal long enough for the elaboration checks to fire.
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    // Mode 3 (and anything else outside 1..2) means no parity bit.
    localparam bit HAS_PARITY = (PARITY_MODE == 1) || (PARITY_MODE == 2);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("param_transmitter: CLKS_PER_BIT must be >= 2");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
        $error("param_transmitter: DATA_BITS must be in 5..9");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
        $error("param_transmitter: STOP_BITS must be 1 or 2");
    end

    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 serial_q, serial_d;
    logic                 done_q, done_d;
    logic                 bit_end;
    logic                 parity_bit;

    assign bit_end = (cnt_q == CNT_LAST);

    // Odd parity makes the total count of ones odd; even parity is the plain XOR.
    assign parity_bit = (PARITY_MODE == 1) ? ~(^data_q) : (^data_q);

    // Next-state logic: every bit lasts exactly CLKS_PER_BIT cycles; idx_q counts
    // data bits in DATA and stop bits in STOP.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        data_d   = data_q;
        serial_d = serial_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                serial_d = 1'b1;
                cnt_d    = '0;
                idx_d    = '0;
                if (Tx_DV_in) begin
                    data_d   = Tx_Byte_in;
                    serial_d = 1'b0;
                    state_d  = START;
                end
            end

            START: begin
                if (bit_end) begin
                    cnt_d    = '0;
                    idx_d    = '0;
                    serial_d = data_q[0];
                    state_d  = DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == DATA_LAST) begin
                        idx_d = '0;
                        if (HAS_PARITY) begin
                            serial_d = parity_bit;
                            state_d  = PARITY;
                        end else begin
                            serial_d = 1'b1;
                            state_d  = STOP;
                        end
                    end else begin
                        idx_d    = idx_q + IDX_W'(1);
                        serial_d = data_q[idx_d];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            PARITY: begin
                if (bit_end) begin
                    cnt_d    = '0;
                    idx_d    = '0;
                    serial_d = 1'b1;
                    state_d  = STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            STOP: begin
                serial_d = 1'b1;
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == STOP_LAST) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                serial_d = 1'b1;
                cnt_d    = '0;
                idx_d    = '0;
                state_d  = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any frame in flight without a Done pulse.
    always_ff @(posedge CLK or negedge RST_N_in) begin
        if (!RST_N_in) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            serial_q <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            serial_q <= serial_d;
            done_q   <= done_d;
        end
    end

    assign Tx_Ready_out  = (state_q == IDLE);
    assign Tx_Active_out = (state_q != IDLE);
    assign Tx_Serial_out = serial_q;
    assign Tx_Done_out   = done_q;

endmodule
